// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between an
// instruction-fetch port (read-only) and a data load/store port. One access
// is in flight at a time; D has priority unless I has lost STARVE_MAX
// consecutive arbitrations. Every output comes straight from a flop.
module mem_port_arbiter #(
    parameter int AW         = 14,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [31:0]   d_addr,
    input  logic [3:0]    d_wen,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wen,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX   = SW'(STARVE_MAX);
    localparam logic [2:0]    LAT_M1 = 3'(MEM_LAT - 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [2:0]      lat_cnt_q, lat_cnt_d;
    logic            owner_i_q, owner_i_d;   // 1: access belongs to I
    logic [3:0]      wen_q, wen_d;           // latched write enables
    logic            i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic            i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [31:0]     i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic            mem_en_q, mem_en_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]      mem_wen_q, mem_wen_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            i_win;

    // Byte-offset and high address bits are don't-care by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

    // Next-state and registered-output computation. The memory-facing
    // outputs and grant pulse are loaded on the arbitration edge so they are
    // live exactly during the ISSUE cycle.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        owner_i_d    = owner_i_q;
        wen_d        = wen_q;
        i_gnt_d      = 1'b0;
        d_gnt_d      = 1'b0;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_en_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wen_d    = 4'b0000;
        mem_wdata_d  = mem_wdata_q;
        i_win        = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    i_win       = i_req && (!d_req || (starve_cnt_q >= SMAX));
                    state_d     = ISSUE;
                    owner_i_d   = i_win;
                    wen_d       = i_win ? 4'b0000 : d_wen;
                    mem_en_d    = 1'b1;
                    mem_wen_d   = i_win ? 4'b0000 : d_wen;
                    mem_addr_d  = i_win ? i_addr[AW+1:2] : d_addr[AW+1:2];
                    mem_wdata_d = i_win ? 32'h0 : d_wdata;
                    i_gnt_d     = i_win;
                    d_gnt_d     = !i_win;
                    if (i_win)
                        starve_cnt_d = '0;
                    else if (i_req && (starve_cnt_q < SMAX))
                        starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_M1;
                state_d   = (wen_q != 4'b0000) ? IDLE : WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == 3'd0) begin
                    state_d    = RESP;
                    i_rvalid_d = owner_i_q;
                    d_rvalid_d = !owner_i_q;
                    if (owner_i_q) i_rdata_d = mem_rdata;
                    else           d_rdata_d = mem_rdata;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            lat_cnt_q    <= '0;
            owner_i_q    <= 1'b0;
            wen_q        <= '0;
            i_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wen_q    <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            owner_i_q    <= owner_i_d;
            wen_q        <= wen_d;
            i_gnt_q      <= i_gnt_d;
            d_gnt_q      <= d_gnt_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign i_gnt     = i_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 for the
// main scenarios, a second with MEM_LAT=3 for the long-latency read.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic preload;
    int   n_chk  = 0;
    int   n_fail = 0;

    // ---- instance A: MEM_LAT=1 ----
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wen, mem_wen;
    logic        mem_en;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(14), .MEM_LAT(1), .STARVE_MAX(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---- instance B: MEM_LAT=3 ----
    logic        c_i_req, c_i_gnt, c_i_rvalid;
    logic [31:0] c_i_addr, c_i_rdata;
    logic        c_d_req, c_d_gnt, c_d_rvalid;
    logic [31:0] c_d_addr, c_d_wdata, c_d_rdata;
    logic [3:0]  c_d_wen, c_mem_wen;
    logic        c_mem_en;
    logic [13:0] c_mem_addr;
    logic [31:0] c_mem_wdata, c_mem_rdata;

    mem_port_arbiter #(.AW(14), .MEM_LAT(3), .STARVE_MAX(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(c_i_req), .i_addr(c_i_addr), .i_gnt(c_i_gnt), .i_rvalid(c_i_rvalid), .i_rdata(c_i_rdata),
        .d_req(c_d_req), .d_addr(c_d_addr), .d_wen(c_d_wen), .d_wdata(c_d_wdata),
        .d_gnt(c_d_gnt), .d_rvalid(c_d_rvalid), .d_rdata(c_d_rdata),
        .mem_en(c_mem_en), .mem_addr(c_mem_addr), .mem_wen(c_mem_wen),
        .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata)
    );

    // Memory models: byte-lane writes, read data after LAT cycles.
    logic [31:0] mem_a [16];
    logic [31:0] pipe_a;
    always @(posedge clk) begin
        if (preload) begin
            mem_a[4] <= 32'hDEADBEEF;
            mem_a[8] <= 32'h11223344;
        end else if (mem_en) begin
            pipe_a <= mem_a[mem_addr[3:0]];
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) mem_a[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = pipe_a;

    logic [31:0] mem_c [16];
    logic [31:0] pipe_c [3];
    always @(posedge clk) begin
        if (preload) mem_c[9] <= 32'hCAFEF00D;
        else if (c_mem_en) pipe_c[0] <= mem_c[c_mem_addr[3:0]];
        pipe_c[1] <= pipe_c[0];
        pipe_c[2] <= pipe_c[1];
    end
    assign c_mem_rdata = pipe_c[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle and land 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_wen}), 32'h0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_rd"}, i_rdata | d_rdata | mem_wdata, 32'h0);
    endtask

    logic exp_i [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b1; preload = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_wen = 0; d_wdata = 0;
        c_i_req = 0; c_i_addr = 0; c_d_req = 0; c_d_addr = 0; c_d_wen = 0; c_d_wdata = 0;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        step(); step();
        preload = 1'b0;
        rst_n = 1'b1;

        // I-only read, cycle 0
        i_req = 1; i_addr = 32'h0000_0010;
        step();
        chk("t1_ignt", 32'({i_gnt, d_gnt, mem_en}), 32'b101);
        chk("t1_maddr", 32'(mem_addr), 32'd4);
        i_req = 0; i_addr = 32'h0000_0FFC;
        step();
        chk("t1_c2", 32'({i_gnt, mem_en, i_rvalid}), 32'b000);
        step();
        chk("t1_rv", 32'({i_rvalid, d_rvalid}), 32'b10);
        chk("t1_rd", i_rdata, 32'hDEADBEEF);

        // D store issued from IDLE (cycle 4)
        step();
        chk("t1_rvdrop", 32'(i_rvalid), 32'd0);
        chk("t1_rdhold", i_rdata, 32'hDEADBEEF);
        d_req = 1; d_addr = 32'h20; d_wen = 4'b0100; d_wdata = 32'h00AB0000;
        step();
        chk("t2_gnt", 32'({d_gnt, i_gnt, mem_en, mem_wen}), 32'b1010100);
        chk("t2_addr", 32'(mem_addr), 32'd8);
        chk("t2_wd", mem_wdata, 32'h00AB0000);
        d_wen = 4'b0000; d_wdata = 0;          // follow-up read of the same word
        step();
        chk("t2_idle", 32'({d_gnt, d_rvalid, mem_en, mem_wen}), 32'h0);
        step();
        chk("t2_regnt", 32'({d_gnt, mem_en, mem_wen}), 32'b110000);
        d_req = 0;
        step();
        chk("t2_norv", 32'(d_rvalid), 32'd0);
        step();
        chk("t2_rv", 32'(d_rvalid), 32'd1);
        chk("t2_merge", d_rdata, 32'h11AB3344);
        step();

        // Contention: both held, D reads; expect D,D,D,I,D
        i_req = 1; i_addr = 32'h10; d_req = 1; d_addr = 32'h20; d_wen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t3_gnt%0d", k), 32'({i_gnt, d_gnt}), 32'({exp_i[k], !exp_i[k]}));
            step(); step();
            chk($sformatf("t3_rv%0d", k), 32'({i_rvalid, d_rvalid}), 32'({exp_i[k], !exp_i[k]}));
            step();
        end
        i_req = 0; d_req = 0;
        chk("t3_ird", i_rdata, 32'hDEADBEEF);

        // Request during busy: I arrives while D read waits
        d_req = 1;
        step();
        chk("t4_dgnt", 32'(d_gnt), 32'd1);
        d_req = 0;
        step();
        i_req = 1; i_addr = 32'h10;
        chk("t4_wait", 32'({i_gnt, mem_en}), 32'b00);
        step();
        chk("t4_resp", 32'({d_rvalid, i_gnt, mem_en}), 32'b100);
        step();
        chk("t4_arb", 32'({i_gnt, mem_en}), 32'b00);
        step();
        chk("t4_igntl", 32'({i_gnt, mem_en}), 32'b11);
        i_req = 0;

        // Reset during WAIT, I request held across reset
        step();
        i_req = 1; i_addr = 32'hFFFF_0013;
        rst_n = 1'b0;
        #1 chk_all_zero("t5_async");
        step(); step();
        chk("t5_inrst", 32'({i_gnt, i_rvalid, d_rvalid, mem_en}), 32'h0);
        rst_n = 1'b1;
        chk("t5_rel", 32'({i_gnt, i_rvalid, d_rvalid}), 32'h0);
        step();
        chk("t5_gnt", 32'({i_gnt, mem_en}), 32'b11);
        chk("t5_addr", 32'(mem_addr), 32'd4);
        i_req = 0;
        step();
        chk("t5_norv", 32'({i_rvalid, d_rvalid}), 32'h0);
        step();
        chk("t5_rv", 32'(i_rvalid), 32'd1);
        chk("t5_rd", i_rdata, 32'hDEADBEEF);

        // MEM_LAT=3 D read on instance B
        c_d_req = 1; c_d_addr = 32'h24;
        step();
        chk("t6_gnt", 32'({c_d_gnt, c_mem_en}), 32'b11);
        chk("t6_addr", 32'(c_mem_addr), 32'd9);
        c_d_req = 0;
        for (int k = 2; k <= 4; k++) begin
            step();
            chk($sformatf("t6_norv%0d", k), 32'({c_d_rvalid, c_mem_en}), 32'h0);
        end
        step();
        chk("t6_rv", 32'(c_d_rvalid), 32'd1);
        chk("t6_rd", c_d_rdata, 32'hCAFEF00D);
        step();
        chk("t6_rvdrop", 32'(c_d_rvalid), 32'd0);
        chk("t6_hold", c_d_rdata, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
